// File: rtl/mips_muldiv_unit_if.sv
// rtl/mips_muldiv_unit_if.sv - request/result bundle between control unit and multiply/divide unit
//   start, op, operand_a, operand_b : request from the control unit (master drives)
//   busy, done, div_by_zero, hi, lo : status and HI/LO results (slave drives)
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of mips_muldiv_unit_if (start/op/operands in; busy/done/div_by_zero/hi/lo out)
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               reset,
  mips_muldiv_unit_if.slave bus
);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     b_reg;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 dbz_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  // op[0]=0 marks the signed variants (MULT, DIV).
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = ~bus.op[0] & bus.operand_a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.operand_b[WIDTH-1];
  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag = b_neg ? -bus.operand_b : bus.operand_b;

  // Shift-add step; the carry out of the add becomes the new top bit.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_reg : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step; remainder is always < divisor so the result fits WIDTH bits.
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH:0]     rem_new;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, b_reg};
  assign rem_new  = rem_ge ? (rem_sh - {1'b0, b_reg}) : rem_sh;
  assign div_next = {rem_new[WIDTH-1:0], acc[WIDTH-2:0], rem_ge};

  // Sign correction applied when leaving FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      b_reg  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: begin
                hi_r   <= bus.operand_a;
                done_r <= 1'b1;
              end
              OP_MTLO: begin
                lo_r   <= bus.operand_a;
                done_r <= 1'b1;
              end
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                if (bus.op[1] && (bus.operand_b == '0)) begin
                  done_r <= 1'b1;
                  dbz_r  <= 1'b1;
                end else begin
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  b_reg  <= b_mag;
                  is_div <= bus.op[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo_r <= q_fix;
            hi_r <= r_fix;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - directed self-checking bench for mips_muldiv_unit at WIDTH 32 and 8
module tb_mips_muldiv_unit;
  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.WIDTH(32)) if32 ();
  mips_muldiv_unit_if #(.WIDTH(8))  if8  ();

  mips_muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(rst), .bus(if32.slave));
  mips_muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(rst), .bus(if8.slave));

  logic        use8 = 1'b0;
  logic        start_drv = 1'b0;
  logic [2:0]  op_drv = 3'b000;
  logic [31:0] a_drv = '0, b_drv = '0;

  assign if32.start     = start_drv & ~use8;
  assign if32.op        = op_drv;
  assign if32.operand_a = a_drv;
  assign if32.operand_b = b_drv;
  assign if8.start      = start_drv & use8;
  assign if8.op         = op_drv;
  assign if8.operand_a  = a_drv[7:0];
  assign if8.operand_b  = b_drv[7:0];

  logic        o_busy, o_done, o_dbz;
  logic [31:0] o_hi, o_lo;
  assign o_busy = use8 ? if8.busy : if32.busy;
  assign o_done = use8 ? if8.done : if32.done;
  assign o_dbz  = use8 ? if8.div_by_zero : if32.div_by_zero;
  assign o_hi   = use8 ? {24'b0, if8.hi} : if32.hi;
  assign o_lo   = use8 ? {24'b0, if8.lo} : if32.lo;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request, waits for done (bounded), reports latency, busy-cycle
  // count, whether hi/lo stayed frozen while waiting, and div_by_zero at done.
  int   lat, busy_cnt;
  logic stable, dbz_at_done;
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    start_drv = 1'b1; op_drv = op; a_drv = a; b_drv = b;
    hi0 = o_hi; lo0 = o_lo;
    @(posedge clk); #1;
    start_drv = 1'b0;
    lat = 0; busy_cnt = 0; stable = 1'b1;
    while (!o_done && lat < 100) begin
      if (o_busy) busy_cnt++;
      if (o_hi !== hi0 || o_lo !== lo0) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    dbz_at_done = o_dbz;
  endtask

  int   n;
  logic seen_done;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_hi", o_hi, 0);
    check("reset_lo", o_lo, 0);
    @(negedge clk) rst = 1'b0;

    do_op(MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_lat", lat, 33);
    check("mult_busy_cycles", busy_cnt, 33);
    check("mult_hilo_frozen", stable, 1);
    check("mult_hi", o_hi, 32'hFFFF_FFFF);
    check("mult_lo", o_lo, 32'hFFFF_FFF1);
    @(posedge clk); #1;
    check("done_one_cycle", o_done, 0);
    check("busy_after_done", o_busy, 0);

    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(MULT, 32'h8000_0000, 32'h8000_0000);
    check("mult_minmin", {o_hi, o_lo}, 64'h4000_0000_0000_0000);

    do_op(DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lat", lat, 33);
    check("div_neg", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(DIVU, 32'd7, 32'd2);
    check("divu_7_2", {o_hi, o_lo}, {32'd1, 32'd3});
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {o_hi, o_lo}, {32'd0, 32'h8000_0000});
    check("div_overflow_no_flag", dbz_at_done, 0);

    do_op(MTHI, 32'h1234, 32'd0);
    check("mthi_lat", lat, 0);
    check("mthi_busy", busy_cnt, 0);
    check("mthi_hi_lo", {o_hi, o_lo}, {32'h1234, 32'h8000_0000});
    do_op(MTLO, 32'h5678, 32'd0);
    check("mtlo_hi_lo", {o_hi, o_lo}, {32'h1234, 32'h5678});
    do_op(DIVU, 32'd9, 32'd0);
    check("dbz_lat", lat, 0);
    check("dbz_flag", dbz_at_done, 1);
    check("dbz_busy", o_busy, 0);
    check("dbz_hilo_kept", {o_hi, o_lo}, {32'h1234, 32'h5678});
    @(posedge clk); #1;
    check("dbz_one_cycle", o_dbz, 0);

    // Reserved op must be ignored.
    @(negedge clk);
    start_drv = 1'b1; op_drv = 3'b110; a_drv = 32'hDEAD; b_drv = 32'd1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    check("reserved_done", o_done, 0);
    check("reserved_busy", o_busy, 0);
    check("reserved_hilo", {o_hi, o_lo}, {32'h1234, 32'h5678});

    // Start while busy is ignored.
    @(negedge clk);
    start_drv = 1'b1; op_drv = MULTU; a_drv = 32'd6; b_drv = 32'd7;
    @(posedge clk); #1;
    start_drv = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start_drv = 1'b1; op_drv = DIVU; a_drv = 32'd100; b_drv = 32'd3;
    @(posedge clk); #1;
    start_drv = 1'b0;
    lat++;
    while (!o_done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("ignored_start_lat", lat, 33);
    check("ignored_start_res", {o_hi, o_lo}, {32'd0, 32'd42});

    // Back-to-back: restart while done is high.
    check("b2b_done_high", o_done, 1);
    do_op(DIVU, 32'd100, 32'd3);
    check("b2b_lat", lat, 33);
    check("b2b_res", {o_hi, o_lo}, {32'd1, 32'd33});

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start_drv = 1'b1; op_drv = MULT; a_drv = 32'd5; b_drv = 32'd7;
    @(posedge clk); #1;
    start_drv = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_busy", o_busy, 0);
    check("async_hilo", {o_hi, o_lo}, 64'd0);
    @(negedge clk) rst = 1'b0;
    seen_done = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (o_done) seen_done = 1'b1;
    end
    check("async_no_done", seen_done, 0);
    do_op(MULTU, 32'd2, 32'd3);
    check("post_reset_mul", {o_hi, o_lo}, {32'd0, 32'd6});

    // WIDTH = 8 instance.
    use8 = 1'b1;
    do_op(MULT, 32'hFD, 32'h05);
    check("w8_mult_lat", lat, 9);
    check("w8_mult_busy", busy_cnt, 9);
    check("w8_mult", {o_hi, o_lo}, {32'hFF, 32'hF1});
    do_op(MULTU, 32'hFF, 32'hFF);
    check("w8_multu", {o_hi, o_lo}, {32'hFE, 32'h01});
    do_op(DIV, 32'hF9, 32'h02);
    check("w8_div_lat", lat, 9);
    check("w8_div", {o_hi, o_lo}, {32'hFF, 32'hFD});
    do_op(DIV, 32'h80, 32'hFF);
    check("w8_div_overflow", {o_hi, o_lo}, {32'h00, 32'h80});
    do_op(DIVU, 32'h07, 32'h02);
    check("w8_divu", {o_hi, o_lo}, {32'h01, 32'h03});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the next-generation MIPS core.
- Adds the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations, which the current single-cycle datapath lacks.
- Sits beside the ALU. The control unit issues a start pulse with an op code and two register-file operands. The core stalls on busy and reads HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; even, >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- operand_a  input  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source).
- operand_b  input  WIDTH  rt value (multiplier/divisor).
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with operand_b=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; iteration state discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0, op MULT/MULTU/DIV/DIVU (divisor non-zero):
  - latch the magnitudes of the operands (signed ops) or the raw operands (unsigned ops);
  - record the result signs; clear counter; go to RUN; busy=1 after E0.
- RUN: one radix-2 step per cycle for WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- RUN -> FIX after the step with counter=WIDTH-1. FIX lasts one cycle.
- At the edge leaving FIX (E0+WIDTH+1):
  - apply two's-complement sign correction, then write hi/lo atomically;
  - done=1 for one cycle; busy=0; state=IDLE.
  - Total latency: result visible WIDTH+1 cycles after E0; busy high for exactly WIDTH+1 cycles.
- Result mapping:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed -2^(WIDTH-1) / -1: lo = 2^(WIDTH-1) (wraps), hi = 0; no flag.
- DIV/DIVU with operand_b=0: no iterations; at E0 done=1 and div_by_zero=1 for one cycle; hi/lo unchanged; busy stays 0.
- MTHI/MTLO: at E0 hi (resp. lo) = operand_a; done=1 for one cycle; busy stays 0; the other register is unchanged.
- Reserved op: start ignored; no state change; no done.
- start while busy=1: ignored; no queuing; operands and op of the running operation unaffected.
- hi/lo hold their previous values throughout RUN/FIX and never show partial results.
- start asserted in the cycle done is high (busy=0) is accepted: back-to-back operations allowed.
- operand_a/operand_b/op need only be valid at E0.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, WIDTH=32 -> busy high 33 cycles; done at E0+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged before done.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload MTHI 0x1234, MTLO 0x5678 (each done one cycle after start, busy=0); DIVU a=9, b=0 -> done and div_by_zero pulse at E0; hi=0x1234, lo=0x5678 unchanged.
- Start MULTU 6*7. At E0+10 pulse start with DIVU 100/3 -> ignored; result hi=0, lo=42 at E0+33. Restart on the done cycle -> accepted; lo=33, hi=1.
- Start MULT. Assert reset at E0+5 (between clock edges) -> busy, hi and lo drop to 0 immediately, without waiting for a clock edge; no done. After release, MULTU 2*3 completes normally with lo=6.
- Repeat the MULT/DIV vectors with WIDTH=8 -> busy for 9 cycles; e.g. DIV 0xF9/0x02 -> lo=0xFD, hi=0xFF.
